// File: rtl/bcd_scan_ctrl_if.sv
// Bus between the game/counter logic, the BCD scan controller and the segment decoder.
interface bcd_scan_ctrl_if;
   logic [6:0] val_a;
   logic [6:0] val_b;
   logic       update;
   logic       busy;
   logic [1:0] ovf;
   logic [3:0] digit_sel;
   logic [3:0] digit_bcd;

   modport master (
      output val_a, val_b, update,
      input  busy, ovf, digit_sel, digit_bcd
   );

   modport slave (
      input  val_a, val_b, update,
      output busy, ovf, digit_sel, digit_bcd
   );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// Two-channel 0-99 to BCD converter with a 4-digit multiplexed display scanner.
// Optional leading-zero blanking of the tens digits: define BCD_SCAN_BLANK_LZ_EN.
module bcd_scan_ctrl #(
   parameter int unsigned PRESCALE = 50000
) (
   input logic             clk,
   input logic             rst_n,
   bcd_scan_ctrl_if.slave  bus
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LastCnt = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {StIdle, StConvA, StConvB, StCommit} state_e;

   state_e     state_q, state_d;
   logic       pend_q, pend_d;
   logic [6:0] rem_q, rem_d;
   logic [3:0] tens_q, tens_d;
   logic [6:0] snap_b_q, snap_b_d;
   logic [1:0] ovf_pend_q, ovf_pend_d;
   logic [3:0] res_at_q, res_at_d, res_ao_q, res_ao_d;
   logic [3:0] res_bt_q, res_bt_d, res_bo_q, res_bo_d;
   logic [3:0] disp_at_q, disp_at_d, disp_ao_q, disp_ao_d;
   logic [3:0] disp_bt_q, disp_bt_d, disp_bo_q, disp_bo_d;
   logic [1:0] ovf_q, ovf_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] sel_q, sel_d;
   logic [3:0] bcd_q, bcd_d;

   logic       take_snap;
   logic       wrap;
   logic [6:0] sat_a, sat_b;

   assign sat_a = (bus.val_a > 7'd99) ? 7'd99 : bus.val_a;
   assign sat_b = (bus.val_b > 7'd99) ? 7'd99 : bus.val_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      rem_d      = rem_q;
      tens_d     = tens_q;
      snap_b_d   = snap_b_q;
      ovf_pend_d = ovf_pend_q;
      res_at_d   = res_at_q;
      res_ao_d   = res_ao_q;
      res_bt_d   = res_bt_q;
      res_bo_d   = res_bo_q;
      disp_at_d  = disp_at_q;
      disp_ao_d  = disp_ao_q;
      disp_bt_d  = disp_bt_q;
      disp_bo_d  = disp_bo_q;
      ovf_d      = ovf_q;
      take_snap  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.update) begin
               take_snap = 1'b1;
               state_d   = StConvA;
            end
         end
         StConvA: begin
            if (bus.update) pend_d = 1'b1;
            if (rem_q >= 7'd10) begin
               rem_d  = rem_q - 7'd10;
               tens_d = tens_q + 4'd1;
            end else begin
               res_at_d = tens_q;
               res_ao_d = rem_q[3:0];
               rem_d    = snap_b_q;
               tens_d   = 4'd0;
               state_d  = StConvB;
            end
         end
         StConvB: begin
            if (bus.update) pend_d = 1'b1;
            if (rem_q >= 7'd10) begin
               rem_d  = rem_q - 7'd10;
               tens_d = tens_q + 4'd1;
            end else begin
               res_bt_d = tens_q;
               res_bo_d = rem_q[3:0];
               state_d  = StCommit;
            end
         end
         StCommit: begin
            disp_at_d = res_at_q;
            disp_ao_d = res_ao_q;
            disp_bt_d = res_bt_q;
            disp_bo_d = res_bo_q;
            ovf_d     = ovf_pend_q;
            // A request arriving in this very cycle is merged like a pending one.
            if (pend_q || bus.update) begin
               take_snap = 1'b1;
               pend_d    = 1'b0;
               state_d   = StConvA;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (take_snap) begin
         rem_d      = sat_a;
         tens_d     = 4'd0;
         snap_b_d   = sat_b;
         ovf_pend_d = {bus.val_b > 7'd99, bus.val_a > 7'd99};
      end
   end

   always_comb begin
      wrap    = (presc_q == LastCnt);
      presc_d = wrap ? '0 : presc_q + PW'(1);
      ptr_d   = wrap ? ptr_q + 2'd1 : ptr_q;
      sel_d   = ~(4'b0001 << ptr_q);
      bcd_d   = disp_bo_q;
      unique case (ptr_q)
         2'd3: bcd_d = disp_at_q;
         2'd2: bcd_d = disp_ao_q;
         2'd1: bcd_d = disp_bt_q;
         2'd0: bcd_d = disp_bo_q;
         default: bcd_d = disp_bo_q;
      endcase
`ifdef BCD_SCAN_BLANK_LZ_EN
      // Odd pointers are the tens digits.
      if (ptr_q[0] && (bcd_d == 4'd0)) bcd_d = 4'hF;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= 1'b0;
         rem_q      <= '0;
         tens_q     <= '0;
         snap_b_q   <= '0;
         ovf_pend_q <= '0;
         res_at_q   <= '0;
         res_ao_q   <= '0;
         res_bt_q   <= '0;
         res_bo_q   <= '0;
         disp_at_q  <= '0;
         disp_ao_q  <= '0;
         disp_bt_q  <= '0;
         disp_bo_q  <= '0;
         ovf_q      <= '0;
         presc_q    <= '0;
         ptr_q      <= '0;
         sel_q      <= 4'b1110;
         bcd_q      <= 4'h0;
      end else begin
         pend_q     <= pend_d;
         rem_q      <= rem_d;
         tens_q     <= tens_d;
         snap_b_q   <= snap_b_d;
         ovf_pend_q <= ovf_pend_d;
         res_at_q   <= res_at_d;
         res_ao_q   <= res_ao_d;
         res_bt_q   <= res_bt_d;
         res_bo_q   <= res_bo_d;
         disp_at_q  <= disp_at_d;
         disp_ao_q  <= disp_ao_d;
         disp_bt_q  <= disp_bt_d;
         disp_bo_q  <= disp_bo_d;
         ovf_q      <= ovf_d;
         presc_q    <= presc_d;
         ptr_q      <= ptr_d;
         sel_q      <= sel_d;
         bcd_q      <= bcd_d;
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.ovf       = ovf_q;
   assign bus.digit_sel = sel_q;
   assign bus.digit_bcd = bcd_q;

endmodule

// File: doc/bcd_scan_ctrl.md
# bcd_scan_ctrl

Time-multiplexed 4-digit seven-segment display controller for two 0–99 values, e.g. score/time pairs.
- Converts each channel to a tens/ones BCD pair with a sequential repeated-subtraction divider.
- Holds the result in display registers that update atomically.
- Scans the four digits with a programmable refresh prescaler.
- Sits between the game/counter logic and the per-digit segment decoder.

## Interface
- PRESCALE, 50000: clocks each digit stays selected; legal range ≥ 2.
- clk  in  1  system clock, all state rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- val_a  in  7  channel A binary value; sampled only on accepted update.
- val_b  in  7  channel B binary value; sampled only on accepted update.
- update  in  1  conversion request, level sampled each cycle.
- busy  out  1  conversion in progress.
- ovf  out  2  bit0 = A saturated, bit1 = B saturated; refreshed at commit.
- digit_sel  out  4  digit enables, active-low, exactly one bit low.
- digit_bcd  out  4  BCD code for the selected digit; 4'hF = blank.

## Operation
- Snapshot: an accepted update captures val_a and val_b. Values > 99 saturate to 99 and set the matching pending ovf bit.
- FSM states:
  - IDLE: update=1 → snapshot, rem ← sat(A), tens ← 0, go to CONV_A.
  - CONV_A: each cycle, if rem ≥ 10 then rem −= 10 and tens += 1. Otherwise latch A result (tens, rem), load rem ← sat(B), tens ← 0, go to CONV_B.
  - CONV_B: same subtraction rule. When rem < 10, latch B result and go to COMMIT.
  - COMMIT: copy both results and ovf into the display registers in one edge, then go to IDLE.
- update while busy sets a pending flag; further updates while pending are merged. In COMMIT with pending set, go straight to CONV_A with a fresh snapshot and clear pending. busy stays 1.
- Scanner:
  - Prescaler counts 0..PRESCALE−1 continuously. On wrap, the digit pointer advances 0→1→2→3→0.
  - Digit mapping: pointer 3 = A tens, 2 = A ones, 1 = B tens, 0 = B ones.
  - digit_sel = ~(4'b0001 << pointer).
- The scanner runs independently of the FSM. It always shows the display registers and never shows intermediate divider state.
- Width rules:
  - rem: 7 bits.
  - tens counter: 4 bits, maximum 9 after saturation.
  - Prescaler: $clog2(PRESCALE) bits.

## Timing
- Reset values:
  - Outputs: busy=0, ovf=2'b00, digit_sel=4'b1110, digit_bcd=4'h0.
  - Internal: FSM=IDLE, pending=0, display registers all 0, pointer=0, prescaler=0.
- rst_n low mid-conversion aborts immediately. The snapshot and pending request are lost.
- busy rises on the edge that accepts update. It falls on the edge leaving COMMIT, which is the same edge the display registers and ovf update.
- Conversion latency = tens(A) + tens(B) + 3 cycles:
  - CONV_A: tens(A)+1 cycles.
  - CONV_B: tens(B)+1 cycles.
  - COMMIT: 1 cycle.
- digit_sel and digit_bcd are registered and change on the same edge, one cycle after prescaler wrap.
- A commit coinciding with a pointer advance shows the new value on that digit at the next edge. Digits never show mixed old/new tens/ones within one slot update.

## Configuration
- BCD_SCAN_BLANK_LZ_EN:
  - Defined: leading-zero blanking. A tens digit of 0 outputs digit_bcd=4'hF for digit 3 or 1; ones digits are never blanked.
  - Undefined: all four digits always show their BCD value, 0 included.

## Test plan
- Reset: hold rst_n=0 → digit_sel=1110, digit_bcd=0, busy=0, ovf=00. Release with PRESCALE=4 → a full scan shows four zeros.
- val_a=57, val_b=3, one-cycle update → busy high exactly 8 cycles. Scan then shows pointer3=5, 2=7, 1=0 (4'hF with BCD_SCAN_BLANK_LZ_EN), 0=3.
- val_a=127, val_b=99, update → busy high 21 cycles. ovf=01 after commit; all four digits read 9.
- Back-to-back requests: update at cycle 0 (A=10, B=10) and again at cycle 2 (A=0, B=0) → busy stays continuously high for 5+3=8 cycles. Final display is 00/00; the 10/10 result is committed transiently at cycle 5.
- Reset mid-conversion: update with A=90, drop rst_n in CONV_A → outputs return to reset values. Release with no further update → display stays 0, busy=0.
- Scan order with PRESCALE=4: digit_sel steps 1110→1101→1011→0111→1110, each held 4 cycles, with exactly one bit low at every edge.
